// File: rtl/pipe_skid_stage_pkg.sv
// pipe_skid_stage_pkg: shared pipeline stage state encoding and bubble constants
// Holds the skid FSM encoding (EMPTY/ONE/FULL, numerically equal to occupancy),
// the per-pipeline NOP/bubble payloads, and the state->occupancy helper.
package pipe_skid_stage_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;
  localparam logic [31:0] NOP_INSN    = 32'h0000_0013;
  localparam logic [31:0] BUBBLE_ZERO = 32'h0000_0000;
  function automatic logic [1:0] occ_of(skid_state_e s);
    return s == ST_FULL ? 2'd2 : s == ST_ONE ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline stage, single register or two-entry skid
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               synchronous kill of every held entry (beats accept/consume)
//   in_valid/in_ready   upstream handshake, in_data upstream payload
//   out_valid/out_ready downstream handshake, out_data payload (BUBBLE when idle)
//   occ                 number of held entries, 0..2
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int                 DATA_W = 32,
  parameter bit                 SKID   = 1'b1,
  parameter logic [DATA_W-1:0]  BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);
  if (SKID) begin : g_skid
    skid_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
    logic              ready_q;
    logic              acc, cons;
    assign acc       = in_valid & ready_q;
    assign cons      = out_valid & out_ready;
    assign in_ready  = ready_q;
    assign out_valid = state_q != ST_EMPTY;
    // main_q is reloaded with BUBBLE whenever the stage empties, so it can drive out_data directly
    assign out_data  = main_q;
    assign occ       = occ_of(state_q);
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
        state_d = ST_EMPTY;
        main_d  = BUBBLE;
        skid_d  = BUBBLE;
      end else begin
        case (state_q)
          ST_EMPTY: if (acc) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
          ST_ONE: if (acc && cons) begin
            main_d = in_data;
          end else if (acc) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (cons) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
          end
          ST_FULL: if (cons) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end
          default: state_d = ST_EMPTY;
        endcase
      end
    end
    // ready is a pure register: it looks ahead at the next state, so out_ready never reaches in_ready
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_EMPTY;
        main_q  <= BUBBLE;
        skid_q  <= BUBBLE;
        ready_q <= 1'b0;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        ready_q <= state_d != ST_FULL;
      end
    end
  end else begin : g_reg
    logic              valid_q, valid_d, armed_q;
    logic [DATA_W-1:0] main_q, main_d;
    logic              acc, cons;
    // armed_q holds in_ready low from reset until the first clock edge after release
    assign in_ready  = armed_q & (out_ready | ~valid_q);
    assign acc       = in_valid & in_ready;
    assign cons      = valid_q & out_ready;
    assign out_valid = valid_q;
    assign out_data  = main_q;
    assign occ       = {1'b0, valid_q};
    assign valid_d   = flush ? 1'b0 : acc ? 1'b1 : cons ? 1'b0 : valid_q;
    assign main_d    = flush ? BUBBLE : acc ? in_data : cons ? BUBBLE : main_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        main_q  <= BUBBLE;
        armed_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
        main_q  <= main_d;
        armed_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: scoreboard bench over six stage variants (SKID 0/1, widths 1/32/104)
module tb_pipe_skid_stage;
  import pipe_skid_stage_pkg::*;
  localparam logic [31:0]  A_BUB = 32'hDEAD_BEEF;
  localparam logic [103:0] F_BUB = {13{8'hA5}};
  logic clk, rst, flush, in_valid, out_ready, live;
  logic [103:0] in_data;
  int checks = 0;
  int errors = 0;
  logic [103:0] sb [6][$];
  logic a_ir, a_ov, b_ir, b_ov, c_ir, c_ov, d_ir, d_ov, e_ir, e_ov, f_ir, f_ov;
  logic [31:0] a_od, b_od;
  logic [0:0] c_od, d_od;
  logic [103:0] e_od, f_od;
  logic [1:0] a_occ, b_occ, c_occ, d_occ, e_occ, f_occ;

  pipe_skid_stage #(.DATA_W(32), .SKID(1'b1), .BUBBLE(A_BUB)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_ir), .in_data(in_data[31:0]),
    .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od), .occ(a_occ));
  pipe_skid_stage #(.DATA_W(32), .SKID(1'b0), .BUBBLE(NOP_INSN)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_ir), .in_data(in_data[31:0]),
    .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od), .occ(b_occ));
  pipe_skid_stage #(.DATA_W(1), .SKID(1'b1), .BUBBLE(1'b1)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_ir), .in_data(in_data[0:0]),
    .out_valid(c_ov), .out_ready(out_ready), .out_data(c_od), .occ(c_occ));
  pipe_skid_stage #(.DATA_W(1), .SKID(1'b0)) u_d (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d_ir), .in_data(in_data[0:0]),
    .out_valid(d_ov), .out_ready(out_ready), .out_data(d_od), .occ(d_occ));
  pipe_skid_stage #(.DATA_W(104), .SKID(1'b1)) u_e (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(e_ir), .in_data(in_data),
    .out_valid(e_ov), .out_ready(out_ready), .out_data(e_od), .occ(e_occ));
  pipe_skid_stage #(.DATA_W(104), .SKID(1'b0), .BUBBLE(F_BUB)) u_f (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(f_ir), .in_data(in_data),
    .out_valid(f_ov), .out_ready(out_ready), .out_data(f_od), .occ(f_occ));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) live <= 1'b0;
    else live <= 1'b1;
  end

  task automatic chk(input string tag, input logic [103:0] obs, input logic [103:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int id, input bit skid, input logic ir, input logic ov, input logic [103:0] od,
                     input logic [103:0] bub, input logic [1:0] occ, input logic [103:0] din);
    logic [103:0] exp;
    if (rst) begin
      chk($sformatf("rst_ov[%0d]", id), ov, 0);
      chk($sformatf("rst_occ[%0d]", id), occ, 0);
      chk($sformatf("rst_data[%0d]", id), od, bub);
      chk($sformatf("rst_ready[%0d]", id), ir, 0);
      sb[id].delete();
      return;
    end
    chk($sformatf("occ[%0d]", id), occ, sb[id].size());
    chk($sformatf("occ_max[%0d]", id), occ <= (skid ? 2 : 1), 1);
    if (!ov) chk($sformatf("bubble[%0d]", id), od, bub);
    if (skid) chk($sformatf("ready_skid[%0d]", id), ir, live && occ != 2);
    else chk($sformatf("ready_reg[%0d]", id), ir, live && (out_ready || !ov));
    if (ov && out_ready) begin
      chk($sformatf("consume_nonempty[%0d]", id), sb[id].size() != 0, 1);
      if (sb[id].size() != 0) begin
        exp = sb[id].pop_front();
        chk($sformatf("order[%0d]", id), od, exp);
      end
    end
    if (flush) sb[id].delete();
    else if (in_valid && ir) sb[id].push_back(din);
  endtask

  always @(negedge clk) begin
    mon(0, 1'b1, a_ir, a_ov, 104'(a_od), 104'(A_BUB), a_occ, 104'(in_data[31:0]));
    mon(1, 1'b0, b_ir, b_ov, 104'(b_od), 104'(NOP_INSN), b_occ, 104'(in_data[31:0]));
    mon(2, 1'b1, c_ir, c_ov, 104'(c_od), 104'(1), c_occ, 104'(in_data[0]));
    mon(3, 1'b0, d_ir, d_ov, 104'(d_od), 104'(0), d_occ, 104'(in_data[0]));
    mon(4, 1'b1, e_ir, e_ov, e_od, 104'(0), e_occ, in_data);
    mon(5, 1'b0, f_ir, f_ov, f_od, F_BUB, f_occ, in_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    #1;
    chk("reset_ov", a_ov, 0);
    chk("reset_occ", a_occ, 0);
    chk("reset_data", a_od, A_BUB);
    chk("reset_ready", a_ir, 0);
    repeat (2) tick();
    chk("ready_in_reset", a_ir, 0);
    rst = 1'b0;
    #1;
    chk("ready_before_edge", a_ir, 0);
    tick();
    chk("ready_after_edge", a_ir, 1);
    in_valid = 1'b1;
    in_data = 104'hA;
    tick();
    chk("hold_occ1", a_occ, 1);
    chk("hold_data_a", a_od, 32'hA);
    in_data = 104'hB;
    tick();
    chk("full_occ", a_occ, 2);
    chk("full_ready", a_ir, 0);
    chk("full_data_a", a_od, 32'hA);
    in_valid = 1'b0;
    tick();
    chk("held_stable", a_od, 32'hA);
    chk("held_valid", a_ov, 1);
    out_ready = 1'b1;
    tick();
    chk("drain_b", a_od, 32'hB);
    chk("drain_occ1", a_occ, 1);
    tick();
    chk("drain_empty_occ", a_occ, 0);
    chk("drain_empty_ov", a_ov, 0);
    chk("drain_bubble", a_od, A_BUB);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 104'h11;
    tick();
    in_data = 104'h12;
    tick();
    chk("pre_flush_occ", a_occ, 2);
    in_data = 104'hC;
    flush = 1'b1;
    tick();
    chk("flush_ov", a_ov, 0);
    chk("flush_occ", a_occ, 0);
    chk("flush_bubble", a_od, A_BUB);
    chk("flush_ready", a_ir, 1);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("no_c_after_flush", a_ov, 0);
    end
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 104'h21;
    tick();
    in_data = 104'h22;
    flush = 1'b1;
    tick();
    chk("flush_drop_accept", a_occ, 0);
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("flush_drop_ov", a_ov, 0);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data = 104'(i);
      tick();
      chk("stream_ov", a_ov, 1);
      chk("stream_data", a_od, 32'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end", a_ov, 0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 104'h31;
    tick();
    in_data = 104'h32;
    tick();
    chk("midrst_pre_occ", a_occ, 2);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("midrst_ov", a_ov, 0);
    chk("midrst_occ", a_occ, 0);
    chk("midrst_data", a_od, A_BUB);
    chk("midrst_ready", a_ir, 0);
    tick();
    rst = 1'b0;
    chk("release_ready_low", a_ir, 0);
    tick();
    chk("release_ready_high", a_ir, 1);
    chk("release_no_entry", a_ov, 0);
    for (int n = 0; n < 300; n++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 1) == 1;
      in_data = {$urandom(), $urandom(), $urandom(), 8'($urandom())};
      tick();
    end
    for (int n = 0; n < 400; n++) begin
      in_valid = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 19) == 0;
      in_data = {$urandom(), $urandom(), $urandom(), 8'($urandom())};
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 6; i++) chk($sformatf("final_empty[%0d]", i), sb[i].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DATA_W, default 32: payload width in bits, legal range 1..512.
REQ-002 Parameter SKID, default 1: 0 selects a single-register stage; 1 selects a two-entry skid stage with registered in_ready.
REQ-003 Parameter BUBBLE, default all-zero DATA_W bits: payload value driven on out_data whenever out_valid=0.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port flush, input, 1: synchronous kill of every held entry.
REQ-007 Port in_valid, input, 1: upstream entry present.
REQ-008 Port in_ready, output, 1: stage accepts an entry this cycle.
REQ-009 Port in_data, input, DATA_W: upstream payload.
REQ-010 Port out_valid, output, 1: downstream entry present.
REQ-011 Port out_ready, input, 1: downstream consumes the entry this cycle.
REQ-012 Port out_data, output, DATA_W: downstream payload.
REQ-013 Port occ, output, 2: number of held entries, 0..2 (max 1 when SKID=0).

Function
REQ-014 Accept = in_valid & in_ready at a rising edge; consume = out_valid & out_ready at a rising edge.
REQ-015 Payload order preserved: out_data sequence equals accepted in_data sequence; no loss, no duplication.
REQ-016 out_data shall equal BUBBLE whenever out_valid=0.
REQ-017 SKID=0: one register; in_ready = out_ready | ~out_valid (combinational path); latency 1 cycle; full throughput.
REQ-018 SKID=1: main register plus skid register; in_ready is a register output with no combinational path from out_ready.
REQ-019 SKID=1 states: EMPTY (occ=0), ONE (occ=1), FULL (occ=2); in_ready=1 in EMPTY and ONE, 0 in FULL.
REQ-020 SKID=1 transitions: EMPTY->ONE on accept; ONE->ONE on accept with consume; ONE->EMPTY on consume without accept; ONE->FULL on accept without consume; FULL->ONE on consume (skid entry moves to main register the same edge).
REQ-021 SKID=1 latency: entry accepted in EMPTY is on out_data the next cycle; throughput 1 entry/cycle while out_ready=1.
REQ-022 A held entry shall not change out_data while out_valid=1 and out_ready=0.
REQ-023 flush=1: next state EMPTY, occ=0, out_valid=0, both registers loaded with BUBBLE; a same-cycle accept is discarded; consume in the flush cycle still counts downstream.
REQ-024 flush has priority over accept and consume; in_ready is 1 in the cycle after flush.
REQ-025 occ equals accepts minus consumes since the last reset or flush.

Reset
REQ-026 rst=1 asynchronously forces: out_valid=0, occ=0, out_data=BUBBLE, skid register=BUBBLE, state EMPTY.
REQ-027 in_ready shall be 0 while rst=1 and 1 from the first rising edge after rst deasserts.
REQ-028 Reset mid-transfer discards all held entries; no entry is presented after reset release unless newly accepted.

Structure
REQ-029 The shared pipeline package holds the state encoding (EMPTY/ONE/FULL) and the stage NOP/bubble constants; pipeline-specific BUBBLE values come from there.
REQ-030 The block is flat; pipeline stages are built by instantiating it with DATA_W set to the concatenated stage fields.

Verification
REQ-031 rst pulse mid-cycle with occ=2 -> out_valid=0, occ=0, out_data=BUBBLE immediately; in_ready=1 one edge after release.
REQ-032 SKID=1, out_ready=1, stream 0x1..0x8 back-to-back -> outputs 0x1..0x8 on consecutive cycles, first one cycle after first accept.
REQ-033 SKID=1, accept 0xA then 0xB with out_ready=0 -> occ=2, in_ready=0, out_data=0xA held; out_ready=1 -> 0xA then 0xB, occ back to 0.
REQ-034 flush with occ=2 and in_valid=1 (0xC) -> next cycle out_valid=0, occ=0, 0xC never appears.
REQ-035 SKID=0, out_ready toggling 1/0 random, 100 entries -> in_ready tracks out_ready|~out_valid; scoreboard matches order.
REQ-036 Random valid/ready/flush, both SKID values, DATA_W=1 and 104 -> scoreboard order match, occ never exceeds 2 (1 for SKID=0).
